// File: rtl/st_coalesce_buf.sv
// st_coalesce_buf: store buffer between the memory stage and the D-cache port.
//
// A circular FIFO of DEPTH word-sized entries. A store whose tag matches the
// youngest unlocked cached entry merges into it byte by byte. Otherwise the
// store allocates a new entry at the tail. The head entry is presented to the
// D-cache from registers. Loads look up all valid entries combinationally.
// Bytes are forwarded youngest-writer-wins, with partial-hit and uncached
// conflict detection. A level fence request drains the buffer and then
// pulses drained_o.
//
// Ports
//   clk_i, rst_i                 clock, async active-high reset
//   st_valid_i/st_ready_o        store handshake
//   st_addr_i/data/be/uncached   store payload (data lane-aligned)
//   ld_valid_i/ld_addr_i/ld_be_i forwarding lookup
//   ld_hit_o/ld_conflict_o       all bytes found / load must retry
//   ld_data_o                    forwarded bytes, uncovered lanes zero
//   mem_valid_o/mem_ready_i      head entry handshake to D-cache
//   mem_addr/data/be/uncached_o  head entry payload
//   drain_i/drained_o            fence request (level) / completion pulse
//   count_o                      occupied entries
module st_coalesce_buf #(
    parameter  int DEPTH  = 4,
    parameter  int XLEN   = 32,
    parameter  int ADDR_W = 32,
    localparam int BE_W   = XLEN / 8,
    localparam int OFS    = $clog2(BE_W),
    localparam int TAG_W  = ADDR_W - OFS,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              st_valid_i,
    output logic              st_ready_o,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [XLEN-1:0]   st_data_i,
    input  logic [BE_W-1:0]   st_be_i,
    input  logic              st_uncached_i,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [BE_W-1:0]   ld_be_i,
    output logic              ld_hit_o,
    output logic              ld_conflict_o,
    output logic [XLEN-1:0]   ld_data_o,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN-1:0]   mem_data_o,
    output logic [BE_W-1:0]   mem_be_o,
    output logic              mem_uncached_o,
    input  logic              drain_i,
    output logic              drained_o,
    output logic [CW-1:0]     count_o
);

    typedef enum logic {RUN, DRAIN} state_e;

    // Entry storage
    logic [DEPTH-1:0] valid_q, lock_q, unc_q;
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [BE_W-1:0]  be_q   [DEPTH];

    logic [PW-1:0]    head_q, tail_q, youngest;
    logic [CW-1:0]    count_q;
    state_e           state_q;
    logic             drained_q;

    logic [TAG_W-1:0] st_tag, ld_tag;
    logic [XLEN-1:0]  st_data_m;
    logic             merge_ok, full, push, do_merge, do_alloc, pop;

    // Low address bits select a lane inside the word and are not stored.
    logic unused_ofs;
    assign unused_ofs = ^{st_addr_i[OFS-1:0], ld_addr_i[OFS-1:0]};

    assign st_tag   = st_addr_i[ADDR_W-1:OFS];
    assign ld_tag   = ld_addr_i[ADDR_W-1:OFS];
    assign youngest = tail_q - PW'(1);
    assign full     = (count_q == CW'(DEPTH));

    // The head is on the D-cache port whenever the buffer is non-empty. So it
    // is treated as locked before its lock bit lands. This keeps mem_* stable
    // and stops a merge from racing a pop of the same entry.
    assign merge_ok = (count_q != '0)
                   && !lock_q[youngest] && (youngest != head_q)
                   && (tag_q[youngest] == st_tag)
                   && !unc_q[youngest] && !st_uncached_i;

    assign st_ready_o = (state_q == RUN) && (merge_ok || !full);
    assign push       = st_valid_i && st_ready_o;
    assign do_merge   = push && merge_ok;
    assign do_alloc   = push && !merge_ok;
    assign pop        = mem_valid_o && mem_ready_i;

    // A new entry holds only the enabled bytes; the other lanes read as zero.
    always_comb begin
        st_data_m = '0;
        for (int b = 0; b < BE_W; b++)
            if (st_be_i[b]) st_data_m[8*b +: 8] = st_data_i[8*b +: 8];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            lock_q  <= '0;
            unc_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            if (count_q != '0) lock_q[head_q] <= 1'b1;
            if (do_merge) begin
                for (int b = 0; b < BE_W; b++)
                    if (st_be_i[b]) data_q[youngest][8*b +: 8] <= st_data_i[8*b +: 8];
                be_q[youngest] <= be_q[youngest] | st_be_i;
            end
            // Allocation never targets the popped slot: tail == head with
            // a non-empty buffer means full, and full blocks allocation.
            if (do_alloc) begin
                valid_q[tail_q] <= 1'b1;
                lock_q[tail_q]  <= 1'b0;
                unc_q[tail_q]   <= st_uncached_i;
                tag_q[tail_q]   <= st_tag;
                data_q[tail_q]  <= st_data_m;
                be_q[tail_q]    <= st_be_i;
                tail_q          <= tail_q + PW'(1);
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                lock_q[head_q]  <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            count_q <= count_q + CW'(do_alloc) - CW'(pop);
        end
    end

    // Fence drain FSM. The pulse is registered, so it appears in the first
    // cycle back in RUN.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            drained_q <= 1'b0;
        end else begin
            drained_q <= 1'b0;
            case (state_q)
                RUN:   if (drain_i) state_q <= DRAIN;
                DRAIN: if (count_q == '0) begin
                    state_q   <= RUN;
                    drained_q <= 1'b1;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    // Forwarding: scan oldest to youngest so later writers overwrite lanes.
    logic [BE_W-1:0] fwd_cov, covered;
    logic [XLEN-1:0] fwd_data;
    logic            unc_match;
    logic [PW-1:0]   idx;

    always_comb begin
        fwd_cov   = '0;
        fwd_data  = '0;
        unc_match = 1'b0;
        idx       = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (valid_q[idx] && (tag_q[idx] == ld_tag)) begin
                if (unc_q[idx]) begin
                    unc_match = 1'b1;
                end else begin
                    for (int b = 0; b < BE_W; b++)
                        if (be_q[idx][b]) begin
                            fwd_cov[b]          = 1'b1;
                            fwd_data[8*b +: 8]  = data_q[idx][8*b +: 8];
                        end
                end
            end
        end
    end

    assign covered       = fwd_cov & ld_be_i;
    assign ld_hit_o      = ld_valid_i && (covered == ld_be_i) && !unc_match;
    assign ld_conflict_o = ld_valid_i
                        && (((covered != '0) && (covered != ld_be_i)) || unc_match);

    always_comb begin
        ld_data_o = '0;
        for (int b = 0; b < BE_W; b++)
            if (ld_valid_i && covered[b]) ld_data_o[8*b +: 8] = fwd_data[8*b +: 8];
    end

    assign mem_valid_o    = (count_q != '0);
    assign mem_addr_o     = {tag_q[head_q], {OFS{1'b0}}};
    assign mem_data_o     = data_q[head_q];
    assign mem_be_o       = be_q[head_q];
    assign mem_uncached_o = unc_q[head_q];
    assign drained_o      = drained_q;
    assign count_o        = count_q;

endmodule

// File: tb/tb_st_coalesce_buf.sv
// Bench for st_coalesce_buf. The reference model is a queue of entries,
// oldest first. It is updated at each rising edge from the inputs that were
// present at that edge.
module tb_st_coalesce_buf;

    localparam int DEPTH = 4;

    logic        clk, rst;
    logic        st_valid, st_ready, st_unc;
    logic [31:0] st_addr, st_data;
    logic [3:0]  st_be;
    logic        ld_valid, ld_hit, ld_conflict;
    logic [31:0] ld_addr, ld_data;
    logic [3:0]  ld_be;
    logic        mem_valid, mem_ready, mem_unc;
    logic [31:0] mem_addr, mem_data;
    logic [3:0]  mem_be;
    logic        drain, drained;
    logic [2:0]  count;

    st_coalesce_buf #(.DEPTH(DEPTH), .XLEN(32), .ADDR_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .st_valid_i(st_valid), .st_ready_o(st_ready), .st_addr_i(st_addr),
        .st_data_i(st_data), .st_be_i(st_be), .st_uncached_i(st_unc),
        .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_be_i(ld_be),
        .ld_hit_o(ld_hit), .ld_conflict_o(ld_conflict), .ld_data_o(ld_data),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
        .mem_data_o(mem_data), .mem_be_o(mem_be), .mem_uncached_o(mem_unc),
        .drain_i(drain), .drained_o(drained), .count_o(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] tag;
        logic [31:0] data;
        logic [3:0]  be;
        bit          unc;
    } ent_t;

    ent_t q[$];
    bit   m_drn, m_pulse;
    int   nchk = 0, nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // The oldest entry is always on the D-cache port, so it can never take
    // a merge.
    function automatic bit m_merge();
        if (q.size() < 2) return 0;
        return q[q.size()-1].tag == st_addr[31:2] && !q[q.size()-1].unc && !st_unc;
    endfunction

    function automatic bit m_ready();
        return !m_drn && (m_merge() || q.size() < DEPTH);
    endfunction

    task automatic check_all();
        logic [31:0] d;
        logic [3:0]  cov;
        bit          um, hit, conf;
        chk("count", count, q.size());
        chk("mem_valid", mem_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("mem_addr", mem_addr, {q[0].tag, 2'b00});
            chk("mem_data", mem_data, q[0].data);
            chk("mem_be", mem_be, q[0].be);
            chk("mem_unc", mem_unc, q[0].unc);
        end
        chk("st_ready", st_ready, m_ready());
        chk("drained", drained, m_pulse);
        d = '0; cov = '0; um = 0;
        foreach (q[k])
            if (q[k].tag == ld_addr[31:2]) begin
                if (q[k].unc) um = 1;
                else for (int b = 0; b < 4; b++)
                    if (q[k].be[b]) begin cov[b] = 1'b1; d[8*b +: 8] = q[k].data[8*b +: 8]; end
            end
        cov = cov & ld_be;
        for (int b = 0; b < 4; b++) if (!cov[b] || !ld_valid) d[8*b +: 8] = 8'h00;
        hit  = ld_valid && cov == ld_be && !um;
        conf = ld_valid && ((cov != 0 && cov != ld_be) || um);
        chk("ld_hit", ld_hit, hit);
        chk("ld_conflict", ld_conflict, conf);
        chk("ld_data", ld_data, d);
    endtask

    task automatic model_edge();
        int   sz;
        bit   rdy, mg, push, pop;
        ent_t e;
        sz   = q.size();
        rdy  = m_ready();
        mg   = m_merge();
        push = st_valid && rdy;
        pop  = sz != 0 && mem_ready;
        if (push && mg) begin
            e = q[sz-1];
            for (int b = 0; b < 4; b++) if (st_be[b]) e.data[8*b +: 8] = st_data[8*b +: 8];
            e.be = e.be | st_be;
            q[sz-1] = e;
        end else if (push) begin
            e.tag = st_addr[31:2]; e.be = st_be; e.unc = st_unc; e.data = '0;
            for (int b = 0; b < 4; b++) if (st_be[b]) e.data[8*b +: 8] = st_data[8*b +: 8];
            q.push_back(e);
        end
        if (pop) void'(q.pop_front());
        m_pulse = m_drn && sz == 0;
        m_drn   = m_drn ? (sz != 0) : drain;
    endtask

    // Check just before the edge, then advance the model over the edge.
    task automatic step();
        #3;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        st_valid = 0; ld_valid = 0; drain = 0;
        rst = 1;
        #1;
        q.delete(); m_drn = 0; m_pulse = 0;
        chk("rst_count", count, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_drained", drained, 0);
        chk("rst_ld_hit", ld_hit, 0);
        chk("rst_ld_conflict", ld_conflict, 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input bit u);
        st_valid = 1; st_addr = a; st_data = d; st_be = be; st_unc = u;
        step();
        st_valid = 0;
    endtask

    initial begin
        int pulses;
        logic [31:0] pool [4];
        pool[0] = 32'h1000; pool[1] = 32'h1004; pool[2] = 32'h2000; pool[3] = 32'h6000;
        rst = 1; st_valid = 0; st_addr = 0; st_data = 0; st_be = 0; st_unc = 0;
        ld_valid = 0; ld_addr = 0; ld_be = 0; mem_ready = 0; drain = 0;
        do_reset();

        // First store into empty buffer; the head then refuses merges.
        put(32'h1000, 32'hAABBCCDD, 4'hF, 0);
        chk("t1_count", count, 1);
        chk("t1_mem_valid", mem_valid, 1);
        chk("t1_mem_addr", mem_addr, 32'h1000);
        chk("t1_mem_data", mem_data, 32'hAABBCCDD);
        put(32'h1000, 32'h11, 4'h1, 0);
        chk("t1_head_locked", count, 2);

        // Byte-lane coalescing behind a locked head.
        do_reset();
        put(32'h1000, 32'h1, 4'hF, 0);
        put(32'h2000, 32'h1111, 4'h3, 0);
        put(32'h2002, 32'h22220000, 4'hC, 0);
        chk("t2_count", count, 2);
        ld_valid = 1; ld_addr = 32'h2000; ld_be = 4'hF;
        #1;
        chk("t2_hit", ld_hit, 1);
        chk("t2_data", ld_data, 32'h22221111);
        step();
        ld_valid = 0;

        // Full buffer: only a merge into the youngest is accepted.
        do_reset();
        put(32'h1000, 32'h1, 4'hF, 0);
        put(32'h1004, 32'h2, 4'hF, 0);
        put(32'h1008, 32'h3, 4'hF, 0);
        put(32'h100C, 32'h4, 4'h1, 0);
        st_valid = 1; st_addr = 32'h1000; st_be = 4'hF;
        #1;
        chk("t3_full_ready", st_ready, 0);
        chk("t3_full_count", count, 4);
        st_addr = 32'h100C;
        #1;
        chk("t3_merge_ready_when_full", st_ready, 1);
        st_valid = 0; st_addr = 32'h1000;
        step();
        mem_ready = 1;
        step();
        mem_ready = 0;
        chk("t3_count_after_pop", count, 3);
        chk("t3_ready_after_pop", st_ready, 1);

        // Full and partial forwarding hits.
        do_reset();
        put(32'h0, 32'h0, 4'hF, 0);
        put(32'h3000, 32'h1234BEEF, 4'h3, 0);
        ld_valid = 1; ld_addr = 32'h3000; ld_be = 4'h3;
        #1;
        chk("t4_hit", ld_hit, 1);
        chk("t4_conf", ld_conflict, 0);
        chk("t4_data", ld_data, 32'h0000BEEF);
        ld_be = 4'hF;
        #1;
        chk("t4_partial_hit", ld_hit, 0);
        chk("t4_partial_conf", ld_conflict, 1);
        step();
        ld_valid = 0;

        // Uncached stores never merge and block forwarding.
        do_reset();
        put(32'h5000, 32'h5, 4'hF, 0);
        put(32'h4000, 32'h55, 4'hF, 1);
        put(32'h4000, 32'h55, 4'hF, 1);
        chk("t5_count", count, 3);
        ld_valid = 1; ld_addr = 32'h4000; ld_be = 4'hF;
        #1;
        chk("t5_conf", ld_conflict, 1);
        chk("t5_hit", ld_hit, 0);
        step();
        ld_valid = 0;

        // Drain three entries; exactly one completion pulse.
        drain = 1; mem_ready = 1;
        step();
        drain = 0;
        #1;
        chk("t6_ready_in_drain", st_ready, 0);
        pulses = 0;
        repeat (6) begin
            step();
            if (drained) pulses++;
        end
        chk("t6_pulses", pulses, 1);
        chk("t6_empty", count, 0);
        mem_ready = 0;

        // Random traffic against the model, with a reset in the middle.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            st_valid  = ($urandom % 2) == 0;
            st_addr   = pool[$urandom % 4] | ($urandom % 4);
            st_data   = $urandom;
            st_be     = 4'($urandom_range(1, 15));
            st_unc    = ($urandom % 8) == 0;
            mem_ready = ($urandom % 3) == 0;
            ld_valid  = ($urandom % 2) == 0;
            ld_addr   = pool[$urandom % 4];
            ld_be     = 4'($urandom_range(1, 15));
            drain     = ($urandom % 25) == 0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/st_coalesce_buf.md
# st_coalesce_buf

Parametrised store buffer that sits between the memory stage and the D-cache request port. It generalises the fixed-depth load/store buffer to configurable depth and data width. Added behaviour: byte-lane store coalescing into the youngest entry, full byte-granular store-to-load forwarding with partial-hit detection, and a fence drain handshake. Uncached (PMA-flagged) stores are never merged or forwarded.

## Interface
- DEPTH, 4, number of entries; must be a power of two and at least 2
- XLEN, 32, data width; BE_W = XLEN/8 and OFS = $clog2(BE_W)
- ADDR_W, 32, address width; word tag = addr[ADDR_W-1:OFS]
- clk_i  in  1  single clock; all state updates on its rising edge
- rst_i  in  1  reset, asynchronous and active-high
- st_valid_i  in  1  store request
- st_ready_o  out  1  store accepted when st_valid_i && st_ready_o
- st_addr_i  in  ADDR_W  store address; low OFS bits ignored
- st_data_i  in  XLEN  store data, lane-aligned
- st_be_i  in  BE_W  byte enables
- st_uncached_i  in  1  PMA uncached flag for this store
- ld_valid_i  in  1  forwarding lookup enable
- ld_addr_i  in  ADDR_W  load address
- ld_be_i  in  BE_W  bytes the load requires
- ld_hit_o  out  1  every required byte is found in the buffer
- ld_conflict_o  out  1  load must stall; retry later
- ld_data_o  out  XLEN  forwarded bytes; uncovered lanes are 0
- mem_valid_o  out  1  head entry presented to D-cache
- mem_ready_i  in  1  D-cache accepts the head entry
- mem_addr_o  out  ADDR_W  head word address; low OFS bits are 0
- mem_data_o  out  XLEN  head data
- mem_be_o  out  BE_W  head byte enables (OR of merged stores)
- mem_uncached_o  out  1  head uncached flag
- drain_i  in  1  fence request, level
- drained_o  out  1  one-cycle pulse when drain completes
- count_o  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Circular FIFO using head and tail pointers plus count; pointers wrap modulo DEPTH.
- Each entry holds: valid, tag, data, be, uncached, locked.
- Head is presented whenever count != 0: mem_valid_o = (count != 0). The head's locked bit sets on the first cycle it is presented.
- Pop on mem_valid_o && mem_ready_i: head advances and count decrements.
- Merge condition (all must hold):
  - count != 0
  - the youngest entry (tail-1) is not locked
  - its tag equals the store's tag
  - neither the entry nor the store is uncached
- On merge:
  - for each i with st_be_i[i] set, entry byte i takes the new data
  - be |= st_be_i
  - count is unchanged
- Otherwise an accepted store allocates at tail.
- st_ready_o = !drain_active && (merge condition || count < DEPTH). It does not depend on mem_ready_i in the same cycle, so no push-on-full even when a pop coincides.
- Forwarding is combinational over all valid entries, scanning oldest to youngest so the youngest writer of each byte wins.
  - covered = OR of matching entries' be, masked by ld_be_i
  - ld_hit_o = ld_valid_i && (covered == ld_be_i) && no uncached match
  - ld_conflict_o = ld_valid_i && ((covered != 0 && covered != ld_be_i) || any uncached tag match)
  - a store accepted in the same cycle is not visible to the lookup
- Drain FSM, states RUN and DRAIN:
  - RUN→DRAIN when drain_i is high
  - DRAIN→RUN when count == 0, with drained_o = 1 for exactly that cycle
  - if count == 0 when drain_i rises, go RUN→DRAIN→RUN with the pulse one cycle later
  - drain_active = (state == DRAIN)

## Timing
- Reset (asynchronous) clears: count_o=0, pointers=0, all valid/locked=0, state=RUN, drained_o=0, mem_valid_o=0, ld_hit_o=0, ld_conflict_o=0.
- A store accepted at edge N into an empty buffer gives mem_valid_o=1 after edge N, i.e. in cycle N+1. Forwarding from it is available from cycle N+1.
- Head outputs come from registers. mem_* stay stable while mem_valid_o && !mem_ready_i.
- Back-to-back pops: one per cycle.
- Simultaneous push and pop in the same cycle leaves count unchanged.
- Reset asserted mid-drain or mid-handshake discards all contents; no mem beat is issued after reset.

## Test plan
- Reset, then store 0x1000/data 0xAABBCCDD/be 0xF with mem_ready_i=0 → count_o=1; mem_valid_o=1 next cycle; mem_addr_o=0x1000; head locked.
- Stores at 0x2000 be 0x3 data 0x1111, then 0x2002 be 0xC data 0x22220000, held behind a locked head → one entry with be=0xF and data=0x22221111; count_o=2.
- Fill DEPTH=4 distinct words with mem_ready_i=0 → st_ready_o=0. A fifth store to a non-youngest tag stalls. Pulse mem_ready_i once → count_o=3 and st_ready_o returns to 1 the next cycle.
- With entry 0x3000 be 0x3 in the buffer, load 0x3000: ld_be 0x3 → ld_hit_o=1, correct bytes; ld_be 0xF → ld_conflict_o=1, ld_hit_o=0.
- Uncached store to 0x4000 followed by the same store again → two entries, no merge. Load 0x4000 → ld_conflict_o=1.
- Three entries queued, drain_i=1, mem_ready_i=1 → st_ready_o=0; three pops; drained_o pulses for exactly one cycle, in the cycle after count reaches 0.
